// File: rtl/axis_frame_sink_checker.sv
// AXI4-Stream frame sink and checker.
// Consumes one stream, drives tready from a rotating 8-phase backpressure
// mask, parses the Ethernet header on the first beat and checks destination
// MAC, byte length against tuser[15:0] and tkeep legality. Saturating
// statistics and per-frame done/error pulses are provided for self-test.
//
// Ports:
//   axis_aclk, axis_resetn           clock, async active-low reset
//   s_axis_*                         slave stream (tready registered)
//   bp_mask                          tready pattern, bit i used in phase i
//   exp_dst_mac, check_mac_en        destination MAC check control
//   stats_clear                      sync clear of counters and last_* regs
//   in_frame, frame_done, frame_err  frame status (registered)
//   frame_cnt, byte_cnt, err_*_cnt   saturating statistics
//   last_dst_mac, last_src_mac, last_len  header/length of last frame
module axis_frame_sink_checker #(
    parameter int unsigned AXIS_DATA_WIDTH  = 256,
    parameter int unsigned AXIS_TUSER_WIDTH = 128,
    parameter int unsigned MAX_BEATS        = 64
) (
    input  logic                          axis_aclk,
    input  logic                          axis_resetn,
    input  logic [AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tlast,
    input  logic [7:0]                    bp_mask,
    input  logic [47:0]                   exp_dst_mac,
    input  logic                          check_mac_en,
    input  logic                          stats_clear,
    output logic                          in_frame,
    output logic                          frame_done,
    output logic                          frame_err,
    output logic [31:0]                   frame_cnt,
    output logic [47:0]                   byte_cnt,
    output logic [15:0]                   err_mac_cnt,
    output logic [15:0]                   err_len_cnt,
    output logic [15:0]                   err_keep_cnt,
    output logic [15:0]                   err_runaway_cnt,
    output logic [47:0]                   last_dst_mac,
    output logic [47:0]                   last_src_mac,
    output logic [15:0]                   last_len
);

    localparam int unsigned KEEP_W  = AXIS_DATA_WIDTH / 8;
    localparam int unsigned CNT_W   = $clog2(KEEP_W + 1);
    localparam int unsigned BEAT_W  = $clog2(MAX_BEATS + 1);
    localparam int unsigned MIN_LEN = 14;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BODY  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          phase_q;
    logic [BEAT_W-1:0]   beat_q;
    logic [15:0]         len_q;
    logic [15:0]         exp_len_q;
    logic [47:0]         dst_q, src_q;
    logic                mac_err_q, keep_err_q, runaway_q;

    logic                hs_c;
    logic [CNT_W-1:0]    beat_bytes_c;
    logic                keep_bad_c;
    logic [47:0]         hdr_dst_c, hdr_src_c;
    logic [BEAT_W-1:0]   beat_inc_c;
    logic                runaway_hit_c;
    logic [16:0]         len_sum_c;
    logic [48:0]         byte_sum_c;
    logic                len_err_c, any_err_c;

    // Upper tdata/tuser bits carry no checked content.
    logic unused_bits;
    assign unused_bits = ^{s_axis_tdata[AXIS_DATA_WIDTH-1:96],
                           s_axis_tuser[AXIS_TUSER_WIDTH-1:16]};

    function automatic logic [CNT_W-1:0] popcount(input logic [KEEP_W-1:0] k);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < int'(KEEP_W); i++) begin
            n = n + CNT_W'(k[i]);
        end
        return n;
    endfunction

    // Beat decode: handshake, byte count, keep legality, header fields.
    always_comb begin
        hs_c         = s_axis_tvalid && s_axis_tready;
        beat_bytes_c = popcount(s_axis_tkeep);
        // Last beat must be a non-empty run of ones starting at bit 0.
        if (s_axis_tlast) begin
            keep_bad_c = (s_axis_tkeep == '0) ||
                         ((s_axis_tkeep & (s_axis_tkeep + KEEP_W'(1))) != '0);
        end else begin
            keep_bad_c = (s_axis_tkeep != '1);
        end
        hdr_dst_c = '0;
        hdr_src_c = '0;
        // byte0 lands in the MAC MSB.
        for (int i = 0; i < 6; i++) begin
            hdr_dst_c[47-8*i -: 8] = s_axis_tdata[8*i +: 8];
            hdr_src_c[47-8*i -: 8] = s_axis_tdata[8*(i+6) +: 8];
        end
        beat_inc_c    = beat_q + BEAT_W'(1);
        runaway_hit_c = !s_axis_tlast && (beat_inc_c >= BEAT_W'(MAX_BEATS));
        len_sum_c     = {1'b0, len_q} + 17'(beat_bytes_c);
        byte_sum_c    = {1'b0, byte_cnt} + 49'(beat_bytes_c);
        len_err_c     = runaway_q || (len_q != exp_len_q) || (len_q < 16'(MIN_LEN));
        any_err_c     = mac_err_q || keep_err_q || len_err_c;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (hs_c) state_d = s_axis_tlast ? S_DONE : S_BODY;
            end
            S_BODY: begin
                if (hs_c) begin
                    if (s_axis_tlast)       state_d = S_DONE;
                    else if (runaway_hit_c) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (hs_c && s_axis_tlast) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) state_q <= S_IDLE;
        else              state_q <= state_d;
    end

    // Backpressure and frame status outputs; tready is held low for the DONE cycle.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            phase_q       <= 3'd0;
            s_axis_tready <= 1'b0;
            in_frame      <= 1'b0;
            frame_done    <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            phase_q       <= phase_q + 3'd1;
            s_axis_tready <= bp_mask[phase_q] && (state_d != S_DONE);
            in_frame      <= (state_d == S_BODY) || (state_d == S_DRAIN);
            frame_done    <= (state_q == S_DONE);
            frame_err     <= (state_q == S_DONE) && any_err_c;
        end
    end

    // Per-frame capture, length/beat accumulation and sticky flags.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            beat_q     <= '0;
            len_q      <= '0;
            exp_len_q  <= '0;
            dst_q      <= '0;
            src_q      <= '0;
            mac_err_q  <= 1'b0;
            keep_err_q <= 1'b0;
            runaway_q  <= 1'b0;
        end else if (hs_c) begin
            unique case (state_q)
                S_IDLE: begin
                    dst_q      <= hdr_dst_c;
                    src_q      <= hdr_src_c;
                    exp_len_q  <= s_axis_tuser[15:0];
                    len_q      <= 16'(beat_bytes_c);
                    beat_q     <= BEAT_W'(1);
                    mac_err_q  <= check_mac_en && (hdr_dst_c != exp_dst_mac);
                    keep_err_q <= keep_bad_c;
                    runaway_q  <= 1'b0;
                end
                S_BODY: begin
                    len_q      <= len_sum_c[16] ? 16'hFFFF : len_sum_c[15:0];
                    beat_q     <= beat_inc_c;
                    keep_err_q <= keep_err_q || keep_bad_c;
                    if (runaway_hit_c) runaway_q <= 1'b1;
                end
                S_DRAIN: begin
                    keep_err_q <= keep_err_q || keep_bad_c;
                end
                default: ;
            endcase
        end
    end

    // Statistics; stats_clear wins over both byte accumulation and frame completion.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            frame_cnt       <= '0;
            byte_cnt        <= '0;
            err_mac_cnt     <= '0;
            err_len_cnt     <= '0;
            err_keep_cnt    <= '0;
            err_runaway_cnt <= '0;
            last_dst_mac    <= '0;
            last_src_mac    <= '0;
            last_len        <= '0;
        end else if (stats_clear) begin
            frame_cnt       <= '0;
            byte_cnt        <= '0;
            err_mac_cnt     <= '0;
            err_len_cnt     <= '0;
            err_keep_cnt    <= '0;
            err_runaway_cnt <= '0;
            last_dst_mac    <= '0;
            last_src_mac    <= '0;
            last_len        <= '0;
        end else begin
            if (hs_c) begin
                byte_cnt <= byte_sum_c[48] ? '1 : byte_sum_c[47:0];
            end
            if (state_q == S_DONE) begin
                if (!(&frame_cnt)) frame_cnt <= frame_cnt + 32'd1;
                if (mac_err_q  && !(&err_mac_cnt))     err_mac_cnt     <= err_mac_cnt + 16'd1;
                if (len_err_c  && !(&err_len_cnt))     err_len_cnt     <= err_len_cnt + 16'd1;
                if (keep_err_q && !(&err_keep_cnt))    err_keep_cnt    <= err_keep_cnt + 16'd1;
                if (runaway_q  && !(&err_runaway_cnt)) err_runaway_cnt <= err_runaway_cnt + 16'd1;
                last_dst_mac <= dst_q;
                last_src_mac <= src_q;
                last_len     <= len_q;
            end
        end
    end

endmodule

// File: tb/tb_axis_frame_sink_checker.sv
// Directed bench for axis_frame_sink_checker with a frame-result scoreboard.
module tb_axis_frame_sink_checker;

    localparam int unsigned DW = 256;
    localparam int unsigned KW = DW / 8;
    localparam int unsigned UW = 128;
    localparam int unsigned MB = 4;

    typedef struct packed {
        logic        err;
        logic [15:0] len;
        logic [47:0] dst;
        logic [47:0] src;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] s_axis_tdata;
    logic [KW-1:0] s_axis_tkeep;
    logic [UW-1:0] s_axis_tuser;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [7:0]    bp_mask;
    logic [47:0]   exp_dst_mac;
    logic          check_mac_en;
    logic          stats_clear;
    logic          in_frame, frame_done, frame_err;
    logic [31:0]   frame_cnt;
    logic [47:0]   byte_cnt;
    logic [15:0]   err_mac_cnt, err_len_cnt, err_keep_cnt, err_runaway_cnt;
    logic [47:0]   last_dst_mac, last_src_mac;
    logic [15:0]   last_len;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc = 0;
    int            hs_edge = 0;
    exp_t          sb[$];
    exp_t          mon_e;
    logic [KW-1:0] keep_arr [8];
    logic [47:0]   src_mac;

    axis_frame_sink_checker #(
        .AXIS_DATA_WIDTH (DW),
        .AXIS_TUSER_WIDTH(UW),
        .MAX_BEATS       (MB)
    ) dut (
        .axis_aclk      (clk),
        .axis_resetn    (rst_n),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tkeep   (s_axis_tkeep),
        .s_axis_tuser   (s_axis_tuser),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tlast   (s_axis_tlast),
        .bp_mask        (bp_mask),
        .exp_dst_mac    (exp_dst_mac),
        .check_mac_en   (check_mac_en),
        .stats_clear    (stats_clear),
        .in_frame       (in_frame),
        .frame_done     (frame_done),
        .frame_err      (frame_err),
        .frame_cnt      (frame_cnt),
        .byte_cnt       (byte_cnt),
        .err_mac_cnt    (err_mac_cnt),
        .err_len_cnt    (err_len_cnt),
        .err_keep_cnt   (err_keep_cnt),
        .err_runaway_cnt(err_runaway_cnt),
        .last_dst_mac   (last_dst_mac),
        .last_src_mac   (last_src_mac),
        .last_len       (last_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Contiguous-from-bit-0 and non-empty.
    function automatic bit keep_contig(input logic [KW-1:0] k);
        bit seen_zero;
        seen_zero = 1'b0;
        for (int i = 0; i < int'(KW); i++) begin
            if (!k[i]) seen_zero = 1'b1;
            else if (seen_zero) return 1'b0;
        end
        return (k != '0);
    endfunction

    // Monitor: record tlast handshake edge, pop and compare on frame_done.
    always @(negedge clk) begin
        if (rst_n) begin
            if (s_axis_tvalid && s_axis_tready && s_axis_tlast) hs_edge = cyc + 1;
            if (frame_done) begin
                chk("sb_avail", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    chk("frame_err",    64'(frame_err),    64'(mon_e.err));
                    chk("last_len",     64'(last_len),     64'(mon_e.len));
                    chk("last_dst_mac", 64'(last_dst_mac), 64'(mon_e.dst));
                    chk("last_src_mac", 64'(last_src_mac), 64'(mon_e.src));
                    // Done register set on the edge after the tlast edge, so a
                    // consumer samples it two edges after the handshake.
                    chk("done_latency", 64'(cyc), 64'(hs_edge + 1));
                end
            end
        end
    end

    task automatic set_keep_all();
        for (int i = 0; i < 8; i++) keep_arr[i] = '1;
    endtask

    task automatic send_frame(input int nb, input logic [47:0] dst, input logic [15:0] ulen);
        exp_t          e;
        int            len;
        bit            run, kerr, ok;
        logic [KW-1:0] k;
        logic [DW-1:0] d;
        len = 0; run = 1'b0; kerr = 1'b0;
        for (int b = 0; b < nb; b++) begin
            k = keep_arr[b];
            if (!run) len += $countones(k);
            if (b != nb - 1) begin
                if (k != '1) kerr = 1'b1;
            end else if (!keep_contig(k)) begin
                kerr = 1'b1;
            end
            if (b >= 1 && !run && b != nb - 1 && b + 1 >= int'(MB)) run = 1'b1;
        end
        e.len = 16'(len);
        e.dst = dst;
        e.src = src_mac;
        e.err = run || (len != int'(ulen)) || (len < 14) || kerr ||
                (check_mac_en && (dst != exp_dst_mac));
        sb.push_back(e);
        @(posedge clk); #1;
        for (int b = 0; b < nb; b++) begin
            for (int w = 0; w < int'(DW / 32); w++) d[32*w +: 32] = $urandom();
            if (b == 0) begin
                for (int i = 0; i < 6; i++) begin
                    d[8*i +: 8]     = dst[47-8*i -: 8];
                    d[8*(i+6) +: 8] = src_mac[47-8*i -: 8];
                end
            end
            s_axis_tdata        = d;
            s_axis_tkeep        = keep_arr[b];
            s_axis_tuser        = '0;
            s_axis_tuser[47:16] = $urandom();
            s_axis_tuser[15:0]  = ulen;
            s_axis_tlast        = (b == nb - 1);
            s_axis_tvalid       = 1'b1;
            ok = 1'b0;
            for (int t = 0; t < 100; t++) begin
                @(negedge clk);
                if (s_axis_tready) begin ok = 1'b1; break; end
            end
            chk("hs_wait", 64'(ok), 64'd1);
            if (!ok) begin
                s_axis_tvalid = 1'b0;
                s_axis_tlast  = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_done();
        for (int t = 0; t < 60 && sb.size() != 0; t++) @(negedge clk);
        chk("done_wait", 64'(sb.size()), 64'd0);
        @(negedge clk);
    endtask

    task automatic check_stats(input string tag, input int fr, input int by,
                               input int em, input int el, input int ek, input int er);
        chk({tag, ".frame_cnt"},       64'(frame_cnt),       64'(fr));
        chk({tag, ".byte_cnt"},        64'(byte_cnt),        64'(by));
        chk({tag, ".err_mac_cnt"},     64'(err_mac_cnt),     64'(em));
        chk({tag, ".err_len_cnt"},     64'(err_len_cnt),     64'(el));
        chk({tag, ".err_keep_cnt"},    64'(err_keep_cnt),    64'(ek));
        chk({tag, ".err_runaway_cnt"}, 64'(err_runaway_cnt), 64'(er));
    endtask

    task automatic do_reset();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        stats_clear   = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        sb.delete();
        chk("rst.tready",     64'(s_axis_tready), 64'd0);
        chk("rst.in_frame",   64'(in_frame),      64'd0);
        chk("rst.frame_done", 64'(frame_done),    64'd0);
        chk("rst.frame_cnt",  64'(frame_cnt),     64'd0);
        chk("rst.byte_cnt",   64'(byte_cnt),      64'd0);
        chk("rst.last_len",   64'(last_len),      64'd0);
        rst_n = 1'b1;
        chk("rst.tready_pre_edge", 64'(s_axis_tready), 64'd0);
        @(negedge clk);
        chk("rst.tready_first", 64'(s_axis_tready), 64'(bp_mask[0]));
    endtask

    initial begin
        bit prev;
        rst_n         = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tuser  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        bp_mask       = 8'hFF;
        exp_dst_mac   = 48'h0000_0000_0002;
        check_mac_en  = 1'b1;
        stats_clear   = 1'b0;
        src_mac       = 48'h0A0B_0C0D_0E0F;
        set_keep_all();
        do_reset();

        // Clean 64-byte frame.
        send_frame(2, 48'h0000_0000_0002, 16'd64);
        wait_done();
        check_stats("t1", 1, 64, 0, 0, 0, 0);
        chk("t1.last_len", 64'(last_len), 64'd64);

        // MAC mismatch, then same with check disabled.
        exp_dst_mac = 48'h0000_0000_0003;
        send_frame(2, 48'h0000_0000_0002, 16'd64);
        wait_done();
        check_stats("t2", 2, 128, 1, 0, 0, 0);
        check_mac_en = 1'b0;
        send_frame(2, 48'h0000_0000_0002, 16'd64);
        wait_done();
        check_stats("t3", 3, 192, 1, 0, 0, 0);
        exp_dst_mac  = 48'h0000_0000_0002;
        check_mac_en = 1'b1;

        // Length mismatch on 96 bytes, then a 10-byte runt.
        send_frame(3, 48'h0000_0000_0002, 16'd100);
        wait_done();
        check_stats("t4", 4, 288, 1, 1, 0, 0);
        chk("t4.last_len", 64'(last_len), 64'd96);
        keep_arr[0] = 32'h0000_03FF;
        send_frame(1, 48'h0000_0000_0002, 16'd10);
        wait_done();
        check_stats("t5", 5, 298, 1, 2, 0, 0);
        chk("t5.last_len", 64'(last_len), 64'd10);

        // Non-full middle beat, then non-contiguous last beat.
        set_keep_all();
        keep_arr[1] = 32'h7FFF_FFFF;
        send_frame(3, 48'h0000_0000_0002, 16'd95);
        wait_done();
        check_stats("t6", 6, 393, 1, 2, 1, 0);
        set_keep_all();
        keep_arr[1] = 32'h0000_00F0;
        send_frame(2, 48'h0000_0000_0002, 16'd36);
        wait_done();
        check_stats("t7", 7, 429, 1, 2, 2, 0);

        // Runaway: 6 beats against MAX_BEATS=4.
        set_keep_all();
        do_reset();
        send_frame(6, 48'h0000_0000_0002, 16'd192);
        wait_done();
        check_stats("t8", 1, 192, 0, 1, 0, 1);
        chk("t8.last_len", 64'(last_len), 64'd128);

        // Alternating backpressure and back-to-back frames.
        bp_mask = 8'h55;
        do_reset();
        prev = s_axis_tready;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp55.toggle", 64'(s_axis_tready), 64'(!prev));
            prev = s_axis_tready;
        end
        for (int f = 0; f < 10; f++) send_frame(2, 48'h0000_0000_0002, 16'd64);
        wait_done();
        check_stats("t9", 10, 640, 0, 0, 0, 0);

        // Statistics clear.
        @(posedge clk); #1;
        stats_clear = 1'b1;
        @(posedge clk); #1;
        stats_clear = 1'b0;
        @(negedge clk);
        check_stats("clr", 0, 0, 0, 0, 0, 0);
        chk("clr.last_len",     64'(last_len),     64'd0);
        chk("clr.last_dst_mac", 64'(last_dst_mac), 64'd0);

        // Reset mid-frame, then resend.
        @(posedge clk); #1;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '1;
        s_axis_tuser  = 128'd64;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        for (int t = 0; t < 100 && !s_axis_tready; t++) @(negedge clk);
        if (!s_axis_tready) @(negedge clk);
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
        @(negedge clk);
        chk("mid.in_frame", 64'(in_frame), 64'd1);
        bp_mask = 8'hFF;
        do_reset();
        send_frame(2, 48'h0000_0000_0002, 16'd64);
        wait_done();
        check_stats("mid", 1, 64, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
